// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the machine-external interrupt controller.
// Holds the Wishbone word offsets of the software-visible registers,
// the claim-sequencing state encoding and the "no interrupt" claim ID.
package irq_ctrl_pkg;

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_TRIGGER  = 3'd2;
    localparam logic [2:0] REG_CLAIM    = 3'd3;
    localparam logic [2:0] REG_COMPLETE = 3'd4;

    localparam int NO_ID = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any bit of vec is set and the
// index of the lowest set bit (bit 0 has the highest priority).
// Ports:
//   vec   in  N      request vector
//   valid out 1      at least one bit of vec is set
//   idx   out IDX_W  index of the lowest set bit (0 when valid=0)
module irq_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 5
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (vec[k]) begin
                valid = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-external interrupt controller. Collects N_SRC interrupt lines
// with per-source enable and level/edge trigger, raises meip_o to the
// core, hands out a claim ID on the core's ack pulse and waits for
// software to write that ID to COMPLETE before raising the next request.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   src_i      in  N_SRC  interrupt lines (synchronous to clk_i)
//   meip_o     out 1      external interrupt request to the core
//   irq_ack_i  in  1      one-cycle claim pulse from the core
//   wb_*                  Wishbone classic slave (word address wb_adr_i)
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_SRC-1:0] src_i,
    output logic             meip_o,
    input  logic             irq_ack_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o
);

    logic [N_SRC-1:0] pending, enable, trigger, src_q;
    logic [N_SRC-1:0] pending_nxt, clr, edges, active;
    logic [ID_W-1:0]  claim_id, claim_nxt, win_idx;
    logic             win_valid;
    logic             req, wr, claim_fire, complete_ok;
    logic [31:0]      rd_data;
    state_t           state, state_nxt;

    // A new request is accepted only while no ack is outstanding, which
    // keeps every transfer single-cycle with no back-to-back acks.
    assign req         = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr          = req & wb_we_i & (wb_sel_i == 4'hF);
    assign active      = pending & enable;
    assign claim_fire  = (state == ASSERT) & irq_ack_i;
    assign complete_ok = wr && (wb_adr_i == REG_COMPLETE) &&
                         (wb_dat_i == 32'(claim_id));
    assign edges       = src_i & ~src_q;

    irq_prio_enc #(
        .N     (N_SRC),
        .IDX_W (ID_W)
    ) u_prio (
        .vec   (active),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Edge sources are cleared by write-1 or by being claimed, but a new
    // edge in the same cycle always wins. Level sources just follow the line.
    always_comb begin
        clr = '0;
        if (wr && (wb_adr_i == REG_PENDING))
            clr = wb_dat_i[N_SRC-1:0];
        if (claim_fire && win_valid)
            clr = clr | (N_SRC'(1) << win_idx);
        pending_nxt = (trigger & ((pending & ~clr) | edges)) | (~trigger & src_i);
    end

    always_comb begin
        state_nxt = state;
        claim_nxt = claim_id;
        case (state)
            IDLE: begin
                if (win_valid)
                    state_nxt = ASSERT;
            end
            ASSERT: begin
                // If every request vanished before the ack, the core is
                // handed NO_ID and the controller returns to IDLE.
                if (irq_ack_i) begin
                    claim_nxt = win_valid ? (win_idx + ID_W'(1)) : ID_W'(NO_ID);
                    state_nxt = win_valid ? SERVICE : IDLE;
                end
            end
            SERVICE: begin
                if (complete_ok) begin
                    claim_nxt = ID_W'(NO_ID);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            REG_PENDING: rd_data[N_SRC-1:0] = pending;
            REG_ENABLE:  rd_data[N_SRC-1:0] = enable;
            REG_TRIGGER: rd_data[N_SRC-1:0] = trigger;
            REG_CLAIM:   rd_data[ID_W-1:0]  = claim_id;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending  <= '0;
            enable   <= '0;
            trigger  <= '0;
            src_q    <= '0;
            claim_id <= ID_W'(NO_ID);
            state    <= IDLE;
            meip_o   <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            src_q    <= src_i;
            pending  <= pending_nxt;
            claim_id <= claim_nxt;
            state    <= state_nxt;
            meip_o   <= (state_nxt == ASSERT);
            wb_ack_o <= req;
            wb_dat_o <= req ? rd_data : '0;
            if (wr && (wb_adr_i == REG_ENABLE))
                enable <= wb_dat_i[N_SRC-1:0];
            if (wr && (wb_adr_i == REG_TRIGGER))
                trigger <= wb_dat_i[N_SRC-1:0];
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios from the feature
// list plus a randomized run checked against a per-cycle reference model.
module tb_irq_ctrl;

    localparam int N_SRC = 8;
    localparam int ID_W  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  src = '0;
    logic        irq_ack = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [2:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        meip_o, wb_ack_o;
    logic [31:0] wb_dat_o;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .src_i     (src),
        .meip_o    (meip_o),
        .irq_ack_i (irq_ack),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_we_i   (wb_we),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_dat),
        .wb_sel_i  (wb_sel),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: register contents, the ID currently handed out to
    // software (nonzero = being serviced) and whether a request is raised.
    logic [7:0]  m_pend = '0, m_en = '0, m_trig = '0, m_srcq = '0;
    logic [4:0]  m_claim = '0;
    logic        m_meip = 1'b0, m_ack = 1'b0;
    logic [31:0] m_dat = '0;

    // Advance one clock: compute what the rules say happens at this edge,
    // take the edge, commit, then settle 1 time unit past the edge.
    task automatic cycle();
        logic        req, wr, me_n;
        int          win;
        logic [7:0]  edges, clr, p_n;
        logic [4:0]  c_n;
        logic [31:0] rd;
        req = wb_cyc & wb_stb & ~m_ack;
        wr  = req & wb_we & (wb_sel == 4'hF);
        win = -1;
        for (int k = 0; k < N_SRC; k++)
            if (win < 0 && m_pend[k] && m_en[k]) win = k;
        case (wb_adr)
            3'd0:    rd = {24'b0, m_pend};
            3'd1:    rd = {24'b0, m_en};
            3'd2:    rd = {24'b0, m_trig};
            3'd3:    rd = {27'b0, m_claim};
            default: rd = 32'b0;
        endcase
        edges = src & ~m_srcq;
        clr   = (wr && wb_adr == 3'd0) ? wb_dat[7:0] : 8'h00;
        c_n   = m_claim;
        me_n  = m_meip;
        if (m_meip) begin
            if (irq_ack) begin
                me_n = 1'b0;
                if (win >= 0) begin
                    c_n = 5'(win + 1);
                    clr[win] = 1'b1;
                end else begin
                    c_n = 5'd0;
                end
            end
        end else if (m_claim != 5'd0) begin
            if (wr && wb_adr == 3'd4 && wb_dat == {27'b0, m_claim}) c_n = 5'd0;
        end else if (win >= 0) begin
            me_n = 1'b1;
        end
        for (int k = 0; k < N_SRC; k++)
            p_n[k] = m_trig[k] ? ((m_pend[k] & ~clr[k]) | edges[k]) : src[k];
        @(posedge clk);
        if (rst) begin
            m_pend = '0; m_en = '0; m_trig = '0; m_srcq = '0;
            m_claim = '0; m_meip = 1'b0; m_ack = 1'b0; m_dat = '0;
        end else begin
            if (wr && wb_adr == 3'd1) m_en = wb_dat[7:0];
            if (wr && wb_adr == 3'd2) m_trig = wb_dat[7:0];
            m_pend  = p_n;
            m_srcq  = src;
            m_claim = c_n;
            m_meip  = me_n;
            m_ack   = req;
            m_dat   = req ? rd : 32'b0;
        end
        #1;
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = adr; wb_dat = dat; wb_sel = 4'hF;
        cycle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        cycle();
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [31:0] dat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_adr = adr; wb_sel = 4'hF;
        cycle();
        dat = wb_ack_o ? wb_dat_o : 32'hDEAD_BEEF;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        cycle();
    endtask

    task automatic wait_meip(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (meip_o) ok = 1'b1;
            else cycle();
        end
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL reset_meip got=%0b exp=0", meip_o); end
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%0b exp=0", wb_ack_o); end
        for (int a = 0; a < 4; a++) begin
            wb_read(3'(a), d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
        end
    endtask

    task automatic test_edge_claim();
        logic [31:0] d;
        wb_write(3'd1, 32'h05);
        wb_write(3'd2, 32'h01);
        src[0] = 1'b1;
        cycle();
        src[0] = 1'b0;
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL edge_meip_early got=%0b exp=0", meip_o); end
        cycle();
        checks++; if (meip_o !== 1'b1) begin errors++; $display("FAIL edge_meip_latency got=%0b exp=1", meip_o); end
        pulse_ack();
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL edge_meip_after_ack got=%0b exp=0", meip_o); end
        wb_read(3'd3, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL edge_claim got=%0d exp=1", d); end
        wb_read(3'd0, d);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL edge_pending0 got=%0b exp=0", d[0]); end
        wb_write(3'd4, 32'd1);
        wb_read(3'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL edge_claim_done got=%0d exp=0", d); end
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL edge_idle_meip got=%0b exp=0", meip_o); end
    endtask

    task automatic test_level_priority();
        logic [31:0] d;
        logic ok;
        wb_write(3'd1, 32'hFF);
        wb_write(3'd2, 32'h00);
        src = 8'h48;
        wait_meip(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL level_meip1 got=0 exp=1"); end
        pulse_ack();
        wb_read(3'd3, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL level_claim1 got=%0d exp=4", d); end
        wb_write(3'd4, 32'd4);
        wait_meip(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL level_meip2 got=0 exp=1"); end
        pulse_ack();
        wb_read(3'd3, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL level_claim2 got=%0d exp=4", d); end
        src = 8'h40;
        wb_write(3'd4, 32'd4);
        wait_meip(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL level_meip3 got=0 exp=1"); end
        pulse_ack();
        wb_read(3'd3, d);
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL level_claim3 got=%0d exp=7", d); end
        src = 8'h00;
        wb_write(3'd4, 32'd7);
        cycle(); cycle();
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL level_quiet got=%0b exp=0", meip_o); end
    endtask

    task automatic test_complete_mismatch();
        logic [31:0] d;
        logic ok;
        wb_write(3'd2, 32'h02);
        src[1] = 1'b1; cycle(); src[1] = 1'b0;
        wait_meip(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mism_meip got=0 exp=1"); end
        pulse_ack();
        wb_write(3'd4, 32'd3);
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL mism_meip_stays got=%0b exp=0", meip_o); end
        wb_read(3'd3, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL mism_claim_kept got=%0d exp=2", d); end
        wb_write(3'd4, 32'd2);
        wb_read(3'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL mism_claim_done got=%0d exp=0", d); end
        // Ack while idle must not produce a claim.
        pulse_ack();
        wb_read(3'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL idle_ack_claim got=%0d exp=0", d); end
    endtask

    task automatic test_back_to_back_edge();
        logic [31:0] d;
        logic ok;
        src[1] = 1'b1; cycle(); src[1] = 1'b0;
        wait_meip(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_meip got=0 exp=1"); end
        irq_ack = 1'b1; src[1] = 1'b1;
        cycle();
        irq_ack = 1'b0; src[1] = 1'b0;
        wb_read(3'd3, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL b2b_claim got=%0d exp=2", d); end
        wb_read(3'd0, d);
        checks++; if (d[1] !== 1'b1) begin errors++; $display("FAIL b2b_pending1 got=%0b exp=1", d[1]); end
        // Disabling the claimed source mid-service changes nothing.
        wb_write(3'd1, 32'h00);
        wb_read(3'd3, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL b2b_disable_claim got=%0d exp=2", d); end
        wb_write(3'd1, 32'hFF);
        wb_write(3'd4, 32'd2);
        wait_meip(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_reassert got=0 exp=1"); end
        pulse_ack();
        wb_read(3'd3, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL b2b_claim2 got=%0d exp=2", d); end
        wb_write(3'd4, 32'd2);
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        wb_write(3'd1, 32'h00);
        wb_write(3'd2, 32'h02);
        src[1] = 1'b1; cycle(); src[1] = 1'b0; cycle();
        wb_write(3'd0, 32'hFF);
        wb_read(3'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h exp=0", d); end
        src[1] = 1'b1;
        wb_write(3'd0, 32'h02);
        src[1] = 1'b0;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h02) begin errors++; $display("FAIL w1c_edge_wins got=%h exp=2", d); end
        src[0] = 1'b1;
        wb_write(3'd0, 32'h01);
        wb_read(3'd0, d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL w1c_level_kept got=%0b exp=1", d[0]); end
        src[0] = 1'b0;
        wb_write(3'd0, 32'h02);
        cycle();
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] d;
        logic ok;
        wb_write(3'd1, 32'h01);
        wb_write(3'd2, 32'h01);
        src[0] = 1'b1; cycle(); src[0] = 1'b0;
        wait_meip(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstsvc_meip got=0 exp=1"); end
        pulse_ack();
        wb_read(3'd3, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL rstsvc_claim got=%0d exp=1", d); end
        rst = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 3'd3;
        cycle();
        rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL rstsvc_meip_low got=%0b exp=0", meip_o); end
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rstsvc_ack got=%0b exp=0", wb_ack_o); end
        cycle();
        wb_read(3'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstsvc_claim0 got=%0d exp=0", d); end
        wb_read(3'd1, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstsvc_enable got=%h exp=0", d); end
    endtask

    task automatic test_random();
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            src = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            irq_ack = m_meip ? ($urandom_range(2, 0) == 0) : ($urandom_range(15, 0) == 0);
            rst = ($urandom_range(599, 0) == 0);
            if (wb_cyc && m_ack) begin
                wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
            end else if (!wb_cyc && $urandom_range(2, 0) == 0) begin
                wb_cyc = 1'b1; wb_stb = 1'b1;
                wb_adr = 3'($urandom_range(7, 0));
                wb_we  = 1'($urandom_range(1, 0));
                wb_sel = ($urandom_range(7, 0) == 0) ? 4'($urandom) : 4'hF;
                if (wb_adr == 3'd4)
                    wb_dat = $urandom_range(1, 0) ? {27'b0, m_claim} : 32'($urandom_range(8, 0));
                else if (wb_adr == 3'd1)
                    wb_dat = ($urandom_range(3, 0) == 0) ? $urandom : 32'hFF;
                else
                    wb_dat = $urandom;
            end
            cycle();
            checks++;
            if (meip_o !== m_meip) begin errors++; $display("FAIL rand_meip n=%0d got=%0b exp=%0b", n, meip_o, m_meip); end
            checks++;
            if (wb_ack_o !== m_ack) begin errors++; $display("FAIL rand_ack n=%0d got=%0b exp=%0b", n, wb_ack_o, m_ack); end
            if (m_ack) begin
                checks++;
                if (wb_dat_o !== m_dat) begin errors++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, wb_dat_o, m_dat); end
            end
        end
        irq_ack = 1'b0; rst = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_edge_claim();
        test_level_priority();
        test_complete_mismatch();
        test_back_to_back_edge();
        test_w1c();
        test_reset_mid_service();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Machine-external interrupt controller for the barebones Wishbone SoC.
- Collects N_SRC peripheral interrupt lines and applies per-source enable and level/edge trigger.
- Drives the core's meip_i through meip_o and sequences claim via the core's irq_ack_o, with software completion.
- Configured by software through a Wishbone classic slave port; replaces the hand-written meip/ack logic used in benches.

Parameters:
- N_SRC, 8, number of interrupt sources (1..31).
- ID_W, 5, width of a claim ID; ID 0 means "none", and source k reports ID k+1.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- src_i  in  N_SRC  interrupt request lines, synchronous to clk_i.
- meip_o  out  1  machine external interrupt request to the core.
- irq_ack_i  in  1  one-cycle claim pulse from the core (its irq_ack_o).
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  Wishbone write enable.
- wb_adr_i  in  3  word address (byte address bits [4:2]).
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; a register is written only if all four are set.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.

Behaviour:
- Reset (sync, active-high): PENDING=0, ENABLE=0, TRIGGER=0, src_q=0, claim_id=0, state=IDLE, meip_o=0, wb_ack_o=0, wb_dat_o=0.
- Edge detect: src_q <= src_i every cycle.
  - Edge source (TRIGGER[k]=1): PENDING[k] sets on src_i[k] & ~src_q[k].
  - Level source (TRIGGER[k]=0): PENDING[k] <= src_i[k].
- Selection: lowest index k with PENDING[k] & ENABLE[k] wins; fixed priority, combinational.
- Register map (word address, byte offset):
  - 0, 0x00 PENDING: read-only view; writing 1s clears edge-source bits only.
  - 1, 0x04 ENABLE: read/write, bits [N_SRC-1:0].
  - 2, 0x08 TRIGGER: read/write, 1 = edge, 0 = level.
  - 3, 0x0C CLAIM: read-only, returns claim_id zero-extended.
  - 4, 0x10 COMPLETE: write-only; write the claimed ID to finish servicing.
  - Addresses 5..7 and unused bits read 0; writes to them are ignored.
- Wishbone timing:
  - wb_ack_o is registered and pulses one cycle after wb_cyc_i & wb_stb_i & ~wb_ack_o. Single-cycle transfers, no stall, no back-to-back ack.
  - Register writes take effect at the ack edge. wb_dat_o is valid while wb_ack_o=1.
- FSM:
  - IDLE: meip_o=0. If any enabled pending source exists, go to ASSERT; meip_o=1 from the next cycle (registered, latency 1 from the pending bit).
  - ASSERT: meip_o=1.
    - If irq_ack_i: claim_id <= winner+1, or 0 if none remains (level line dropped). Clear PENDING[winner] if it is an edge source. Go to SERVICE if the ID is nonzero, else IDLE. meip_o=0 next cycle.
    - If the enabled pending set becomes empty without an ack: stay in ASSERT. The core will ack and receive ID 0.
  - SERVICE: meip_o=0.
    - COMPLETE write with data == claim_id: claim_id <= 0, go to IDLE.
    - COMPLETE write with a mismatched ID: ignored, stay in SERVICE.
- Boundary conditions:
  - irq_ack_i outside ASSERT: ignored.
  - COMPLETE written in IDLE or ASSERT: ignored.
  - New edge on the claimed source in the same cycle as the claim: the set wins and PENDING stays 1.
  - Write-1-to-clear and a new edge in the same cycle: the set wins.
  - Software clears ENABLE for the claimed source during SERVICE: no effect until COMPLETE.
  - reset_i mid-service: everything returns to reset values and meip_o=0 the next cycle.
- Nested interrupts are not supported: one claim outstanding at a time.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register offset constants (REG_PENDING=0 … REG_COMPLETE=4);
  - FSM state encoding (IDLE, ASSERT, SERVICE);
  - NO_ID=0.
- One sub-module, irq_prio_enc: N_SRC-bit vector to {valid, lowest-set index}, purely combinational.

Test Plan:
- Reset, then read all registers -> PENDING=0, ENABLE=0, TRIGGER=0, CLAIM=0; meip_o=0.
- ENABLE=0x05, TRIGGER=0x01, pulse src_i[0] one cycle -> meip_o=1 two cycles later.
  - Then pulse irq_ack_i -> meip_o=0, CLAIM reads 1, PENDING[0]=0.
  - Then write COMPLETE=1 -> state IDLE.
- ENABLE=0xFF, level sources 3 and 6 held high -> first ack gives CLAIM=4.
  - COMPLETE=4 -> meip_o reasserts; second ack gives CLAIM=4 again (source 3 is still high).
  - Drop src_i[3], COMPLETE=4 -> next claim returns 7.
- In SERVICE with claim_id=2, write COMPLETE=3 -> ignored, meip_o stays 0.
  - Then write COMPLETE=2 -> return to IDLE.
- Edge source 1 claimed while src_i[1] rises again in the ack cycle -> CLAIM=2, PENDING[1]=1; meip_o reasserts after COMPLETE=2.
- Assert reset_i for one cycle during SERVICE -> next cycle: meip_o=0, CLAIM=0, ENABLE=0, wb_ack_o=0.
